// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: sequencer states, opcodes, ALU/PC encodings
// and the control-word layout used by the sequencer, datapath and bench.
package legv8_pkg;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_LOAD_WB,
        ST_HALT
    } state_t;

    // 11-bit opcodes, IR[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    // 10-bit opcodes, IR[31:22]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    // 8-bit opcodes, IR[31:24]
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    // 6-bit opcodes, IR[31:26]
    localparam logic [5:0]  OP_B  = 6'b000101;
    localparam logic [5:0]  OP_BL = 6'b100101;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_BUS    = 2'b10;
    localparam logic [1:0] PS_OFFSET = 2'b11;

    // The PC source is carried entirely by PS, so the 93-bit word has no separate PC-select bit.
    typedef struct packed {
        logic [63:0] const_val;
        logic        en_pc;
        logic        en_mem;
        logic        en_alu;
        logic        bsel;
        logic        sl;
        logic        wm;
        logic        wr;
        logic [1:0]  ps;
        logic [4:0]  fs;
        logic [4:0]  sb;
        logic [4:0]  sa;
        logic [4:0]  da;
    } ctrl_word_t;

    localparam int CW_W         = 93;
    localparam int CW_DA_LSB    = 0;
    localparam int CW_SA_LSB    = 5;
    localparam int CW_SB_LSB    = 10;
    localparam int CW_FS_LSB    = 15;
    localparam int CW_PS_LSB    = 20;
    localparam int CW_WR        = 22;
    localparam int CW_WM        = 23;
    localparam int CW_SL        = 24;
    localparam int CW_BSEL      = 25;
    localparam int CW_EN_ALU    = 26;
    localparam int CW_EN_MEM    = 27;
    localparam int CW_EN_PC     = 28;
    localparam int CW_CONST_LSB = 29;

endpackage

// File: rtl/legv8_control_fsm_if.sv
// ROM/datapath-facing signals of the LEGv8 control sequencer; master is the
// sequencer, slave is the datapath/ROM side.
interface legv8_control_fsm_if;
    logic [31:0] instruction;
    logic [4:0]  status;
    logic [92:0] control_word;
    logic        halted;

    modport master (
        input  instruction,
        input  status,
        output control_word,
        output halted
    );

    modport slave (
        output instruction,
        output status,
        input  control_word,
        input  halted
    );
endinterface

// File: rtl/legv8_decode.sv
// Combinational LEGv8 decoder: instruction register plus datapath status to the
// EXEC-cycle control word, with a flag for unrecognised opcodes.
module legv8_decode
    import legv8_pkg::*;
(
    input  logic [31:0] ir,
    input  logic [4:0]  status,
    output ctrl_word_t  cw,
    output logic        invalid
);

    // flags = {V, C, N, Z}; codes above LE are treated as always
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic v, c, n, z;
        {v, c, n, z} = flags;
        case (cond)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return c;
            4'b0011: return !c;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return c && !z;
            4'b1001: return !(c && !z);
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [4:0] rtype_fs(input logic [10:0] op);
        case (op)
            OP_ADD, OP_ADDS: return FS_ADD;
            OP_SUB, OP_SUBS: return FS_SUB;
            OP_ORR:          return FS_ORR;
            OP_EOR:          return FS_EOR;
            default:         return FS_AND;
        endcase
    endfunction

    logic [63:0] mem_offset;
    logic [63:0] cond_offset;
    logic [63:0] jump_offset;
    logic        taken;

    assign mem_offset  = {{55{ir[20]}}, ir[20:12]};
    assign cond_offset = {{43{ir[23]}}, ir[23:5], 2'b00};
    assign jump_offset = {{36{ir[25]}}, ir[25:0], 2'b00};

    // Longest opcode first: 11-bit, then 10-, 8- and 6-bit forms
    always_comb begin
        cw      = '0;
        invalid = 1'b0;
        taken   = 1'b0;
        cw.da   = ir[4:0];
        cw.sa   = ir[9:5];
        cw.sb   = ir[20:16];
        case (ir[31:21])
            OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR: begin
                cw.en_alu = 1'b1;
                cw.wr     = 1'b1;
                cw.ps     = PS_INC;
                cw.fs     = rtype_fs(ir[31:21]);
                cw.sl     = (ir[31:21] == OP_ADDS) || (ir[31:21] == OP_SUBS);
            end
            OP_LSL, OP_LSR: begin
                cw.const_val = {58'b0, ir[15:10]};
                cw.bsel      = 1'b1;
                cw.en_alu    = 1'b1;
                cw.wr        = 1'b1;
                cw.ps        = PS_INC;
                cw.fs        = (ir[31:21] == OP_LSL) ? FS_LSL : FS_LSR;
            end
            OP_LDUR: begin
                cw.const_val = mem_offset;
                cw.bsel      = 1'b1;
                cw.fs        = FS_ADD;
                cw.ps        = PS_HOLD;
            end
            OP_STUR: begin
                cw.const_val = mem_offset;
                cw.bsel      = 1'b1;
                cw.fs        = FS_ADD;
                cw.sb        = ir[4:0];
                cw.wm        = 1'b1;
                cw.ps        = PS_INC;
            end
            OP_BR: begin
                cw.sb     = 5'd31;
                cw.fs     = FS_ORR;
                cw.en_alu = 1'b1;
                cw.ps     = PS_BUS;
            end
            default: begin
                case (ir[31:22])
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
                        cw.const_val = {52'b0, ir[21:10]};
                        cw.bsel      = 1'b1;
                        cw.en_alu    = 1'b1;
                        cw.wr        = 1'b1;
                        cw.ps        = PS_INC;
                        case (ir[31:22])
                            OP_ADDI: cw.fs = FS_ADD;
                            OP_SUBI: cw.fs = FS_SUB;
                            OP_ORRI: cw.fs = FS_ORR;
                            default: cw.fs = FS_AND;
                        endcase
                    end
                    default: begin
                        case (ir[31:24])
                            OP_CBZ, OP_CBNZ: begin
                                cw.sa     = 5'd31;
                                cw.sb     = ir[4:0];
                                cw.fs     = FS_ADD;
                                taken     = (ir[31:24] == OP_CBZ) ? status[0] : !status[0];
                                cw.ps     = taken ? PS_OFFSET : PS_INC;
                                cw.const_val = taken ? cond_offset : 64'd0;
                            end
                            OP_BCOND: begin
                                taken     = cond_holds(ir[3:0], status[4:1]);
                                cw.ps     = taken ? PS_OFFSET : PS_INC;
                                cw.const_val = taken ? cond_offset : 64'd0;
                            end
                            default: begin
                                case (ir[31:26])
                                    OP_B: begin
                                        cw.const_val = jump_offset;
                                        cw.ps        = PS_OFFSET;
                                    end
                                    OP_BL: begin
                                        cw.const_val = jump_offset;
                                        cw.ps        = PS_OFFSET;
                                        cw.en_pc     = 1'b1;
                                        cw.wr        = 1'b1;
                                        cw.da        = 5'd30;
                                    end
                                    default: begin
                                        cw      = '0;
                                        invalid = 1'b1;
                                    end
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control sequencer: FETCH latches the instruction, EXEC drives
// the decoded control word, LOAD_WB completes LDUR, HALT stops on a bad opcode.
module legv8_control_fsm
    import legv8_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    legv8_control_fsm_if.master  bus
);

    state_t          state;
    state_t          next_state;
    logic [31:0]     ir;
    ctrl_word_t      dec_cw;
    logic            dec_invalid;
    logic [CW_W-1:0] cw;

    legv8_decode u_decode (
        .ir      (ir),
        .status  (bus.status),
        .cw      (dec_cw),
        .invalid (dec_invalid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_FETCH;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == ST_FETCH) begin
                ir <= bus.instruction;
            end
        end
    end

    // LOAD_WB keeps the EXEC address fields and turns the load result into a register write
    always_comb begin
        next_state = state;
        cw         = '0;
        case (state)
            ST_FETCH: begin
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                cw = dec_cw;
                if (dec_invalid) begin
                    next_state = ST_HALT;
                end else if (ir[31:21] == OP_LDUR) begin
                    next_state = ST_LOAD_WB;
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_LOAD_WB: begin
                cw                         = dec_cw;
                cw[CW_EN_MEM]              = 1'b1;
                cw[CW_WR]                  = 1'b1;
                cw[CW_PS_LSB +: 2]         = PS_INC;
                cw[CW_DA_LSB +: 5]         = ir[4:0];
                next_state                 = ST_FETCH;
            end
            default: begin
                next_state = ST_HALT;
            end
        endcase
    end

    // Blanking during reset keeps an aborted LDUR from writing at the reset edge
    assign bus.control_word = reset ? '0 : cw;
    assign bus.halted       = (state == ST_HALT);

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Randomized self-checking bench for legv8_control_fsm against an
// instruction-level reference model of the control word.
module tb_legv8_control_fsm;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    legv8_control_fsm_if bus ();

    legv8_control_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [92:0] got, input logic [92:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] st);
        bit z, n, c, v;
        z = st[1]; n = st[2]; c = st[3]; v = st[4];
        case (cond)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Expected control word for an instruction in its EXEC (wb=0) or LOAD_WB (wb=1) cycle
    function automatic void model(input logic [31:0] ir, input logic [4:0] st, input bit wb,
                                  output logic [92:0] cw, output bit valid);
        logic [63:0] k;
        logic en_pc, en_mem, en_alu, bsel, sl, wm, wr;
        logic [1:0] ps;
        logic [4:0] fs, da, sa, sb;
        logic [10:0] op11;
        logic [9:0] op10;
        logic [7:0] op8;
        logic [5:0] op6;
        bit hit, take;
        k = 0; en_pc = 0; en_mem = 0; en_alu = 0; bsel = 0; sl = 0; wm = 0; wr = 0;
        ps = 0; fs = 0; da = ir[4:0]; sa = ir[9:5]; sb = ir[20:16];
        op11 = ir[31:21]; op10 = ir[31:22]; op8 = ir[31:24]; op6 = ir[31:26];
        hit = 1; take = 0; valid = 1;
        case (op11)
            11'b10001011000: begin fs = 8;  en_alu = 1; wr = 1; ps = 1; end
            11'b10101011000: begin fs = 8;  en_alu = 1; wr = 1; ps = 1; sl = 1; end
            11'b11001011000: begin fs = 9;  en_alu = 1; wr = 1; ps = 1; end
            11'b11101011000: begin fs = 9;  en_alu = 1; wr = 1; ps = 1; sl = 1; end
            11'b10001010000: begin fs = 0;  en_alu = 1; wr = 1; ps = 1; end
            11'b10101010000: begin fs = 4;  en_alu = 1; wr = 1; ps = 1; end
            11'b11001010000: begin fs = 12; en_alu = 1; wr = 1; ps = 1; end
            11'b11010011011: begin fs = 16; k = 64'(ir[15:10]); bsel = 1; en_alu = 1; wr = 1; ps = 1; end
            11'b11010011010: begin fs = 20; k = 64'(ir[15:10]); bsel = 1; en_alu = 1; wr = 1; ps = 1; end
            11'b11111000010: begin
                k = 64'(longint'($signed(ir[20:12]))); bsel = 1; fs = 8;
                if (wb) begin en_mem = 1; wr = 1; ps = 1; end
            end
            11'b11111000000: begin
                k = 64'(longint'($signed(ir[20:12]))); bsel = 1; fs = 8; wm = 1; ps = 1; sb = ir[4:0];
            end
            11'b11010110000: begin fs = 4; sb = 31; en_alu = 1; ps = 2; end
            default: hit = 0;
        endcase
        if (!hit) begin
            hit = 1;
            case (op10)
                10'b1001000100: fs = 8;
                10'b1101000100: fs = 9;
                10'b1001001000: fs = 0;
                10'b1011001000: fs = 4;
                default: hit = 0;
            endcase
            if (hit) begin k = 64'(ir[21:10]); bsel = 1; en_alu = 1; wr = 1; ps = 1; end
        end
        if (!hit) begin
            hit = 1;
            case (op8)
                8'b10110100: begin take = (st[0] == 1); sa = 31; sb = ir[4:0]; fs = 8; end
                8'b10110101: begin take = (st[0] == 0); sa = 31; sb = ir[4:0]; fs = 8; end
                8'b01010100: take = cond_true(ir[3:0], st);
                default: hit = 0;
            endcase
            if (hit) begin
                ps = take ? 2'd3 : 2'd1;
                k  = take ? 64'(longint'($signed(ir[23:5])) * 4) : 64'd0;
            end
        end
        if (!hit) begin
            hit = 1;
            case (op6)
                6'b000101: begin ps = 3; k = 64'(longint'($signed(ir[25:0])) * 4); end
                6'b100101: begin ps = 3; k = 64'(longint'($signed(ir[25:0])) * 4); en_pc = 1; wr = 1; da = 30; end
                default: hit = 0;
            endcase
        end
        valid = hit;
        if (hit) cw = {k, en_pc, en_mem, en_alu, bsel, sl, wm, wr, ps, fs, sb, sa, da};
        else     cw = '0;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [3:0] cond;
        r = $urandom;
        cond = 4'($urandom_range(0, 14));
        case ($urandom_range(0, 19))
            0:  return {11'b10001011000, r[20:0]};
            1:  return {11'b10101011000, r[20:0]};
            2:  return {11'b11001011000, r[20:0]};
            3:  return {11'b11101011000, r[20:0]};
            4:  return {11'b10001010000, r[20:0]};
            5:  return {11'b10101010000, r[20:0]};
            6:  return {11'b11001010000, r[20:0]};
            7:  return {11'b11010011011, r[20:0]};
            8:  return {11'b11010011010, r[20:0]};
            9:  return {11'b11111000010, r[20:0]};
            10: return {11'b11111000000, r[20:0]};
            11: return {11'b11010110000, r[20:0]};
            12: return {10'b1001000100, r[21:0]};
            13: return {10'b1101000100, r[21:0]};
            14: return {10'b1001001000, r[21:0]};
            15: return {10'b1011001000, r[21:0]};
            16: return {7'b1011010, r[24:0]};
            17: return {8'b01010100, r[23:4], cond};
            18: return {6'b000101, r[25:0]};
            default: return {6'b100101, r[25:0]};
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle; entered and left at a falling edge in FETCH
    task automatic exec_one(input logic [31:0] ir, input logic [4:0] st, input string tag);
        logic [92:0] exp;
        bit valid;
        bus.instruction = ir;
        bus.status = 5'($urandom);
        #1;
        check({tag, "_fetch_cw"}, bus.control_word, '0);
        check({tag, "_fetch_halted"}, {92'b0, bus.halted}, '0);
        @(posedge clock); @(negedge clock);
        bus.instruction = $urandom;
        bus.status = st;
        #1;
        model(ir, st, 1'b0, exp, valid);
        check($sformatf("%s_exec_cw_%h", tag, ir), bus.control_word, exp);
        check({tag, "_exec_halted"}, {92'b0, bus.halted}, '0);
        @(posedge clock); @(negedge clock);
        if (!valid) begin
            for (int i = 0; i < 10; i++) begin
                bus.status = 5'($urandom);
                #1;
                check({tag, "_halt_flag"}, {92'b0, bus.halted}, 93'd1);
                check({tag, "_halt_cw"}, bus.control_word, '0);
                @(posedge clock); @(negedge clock);
            end
            reset = 1'b1;
            @(posedge clock); @(negedge clock);
            reset = 1'b0;
            #1;
            check({tag, "_after_reset_halted"}, {92'b0, bus.halted}, '0);
        end else if (ir[31:21] == 11'b11111000010) begin
            bus.status = 5'($urandom);
            #1;
            model(ir, bus.status, 1'b1, exp, valid);
            check({tag, "_wb_cw"}, bus.control_word, exp);
            @(posedge clock); @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.instruction = '0;
        bus.status = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_cw", bus.control_word, '0);
        check("reset_halted", {92'b0, bus.halted}, '0);
        reset = 1'b0;

        exec_one(32'h910017E1, 5'b00000, "addi");
        exec_one(32'hF8408022, 5'b10101, "ldur");
        exec_one(32'hB4000061, 5'b11110, "cbz_nt");
        exec_one(32'hB4000061, 5'b00001, "cbz_t");
        exec_one(32'hB5000061, 5'b00001, "cbnz_nt");
        exec_one(32'hEB020020, 5'b00000, "subs");
        exec_one(32'h54000040, 5'b00010, "beq_t");
        exec_one(32'hEB020020, 5'b00000, "subs2");
        exec_one(32'h54000040, 5'b00000, "beq_nt");
        exec_one(32'h5400004E, 5'b00000, "bal0");
        exec_one(32'h5400004E, 5'b11111, "bal1");
        exec_one(32'hD61F03C0, 5'b00000, "br");
        exec_one(32'h97FFFFFF, 5'b00000, "bl_neg");

        for (int i = 0; i < 80; i++) begin
            exec_one(gen_instr(), 5'($urandom), "rnd");
        end

        // Reset during LOAD_WB must suppress the write and restart in FETCH
        bus.instruction = 32'hF8408022;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_wb_cw", bus.control_word, '0);
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_fetch_cw", bus.control_word, '0);
        check("abort_halted", {92'b0, bus.halted}, '0);
        exec_one(32'h910017E1, 5'b00000, "post_abort");

        exec_one(32'h00000000, 5'b00000, "halt");
        exec_one(32'h910017E1, 5'b00000, "post_halt");
        exec_one(32'hF8408022, 5'b00000, "post_halt_ldur");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
